tmds_align: RTL and testbench
=============================

Name: tmds_align

Overview:
- Symbol-boundary aligner between the 10:1 deserializer and the TMDS/TERC4 decoder; one instance per TMDS channel.
- Takes raw 10-bit words from the deserializer. The word boundary is arbitrary at power-up.
- Barrel-rotates the words by a selectable bit offset 0..9 and searches offsets until the output carries runs of control-period tokens.
- Then reports lock and supervises it; the aligned word drives the decoder's 10-bit input.

Parameters:
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096: words without any control token before slipping to the next offset while searching.
- LOSS_TIMEOUT, 16384: words without any control token before dropping lock.

Ports:
- clk  in  1  symbol clock, one raw word per cycle.
- reset_n  in  1  asynchronous active-low reset.
- in  in  10  raw deserializer word; bit 0 is the earliest-received bit.
- slip_req  in  1  one-cycle pulse that forces an immediate slip to the next offset, from any state.
- out  out  10  aligned word, feeds the decoder.
- locked  out  1  high while in LOCKED.
- offset  out  4  current rotation offset, 0..9.
- slip  out  1  one-cycle pulse on every offset change.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out=0, locked=0, offset=0, slip=0, state=SEARCH, all counters 0.
- Datapath:
  - prev holds the previous in word.
  - window[19:0] = {in, prev}, so the older word sits in the low bits.
  - out <= window[offset+9 : offset], registered.
  - Latency is 1 clk from in to out. With offset=0, out is the word sampled one cycle earlier (prev).
- Token match: is_ctrl is true when out is one of 0x354, 0x0AB, 0x154, 0x2AB. TERC4 tokens do not count.
- Counters:
  - run_cnt, width $clog2(CTRL_RUN+1), saturating.
  - idle_cnt, width $clog2(max(SEARCH_TIMEOUT, LOSS_TIMEOUT)+1).
- Slip action:
  - offset <= (offset==9) ? 0 : offset+1.
  - slip <= 1 for one cycle; run_cnt and idle_cnt clear; next state is SETTLE.
- State SEARCH:
  - On is_ctrl: run_cnt++, idle_cnt <= 0. When run_cnt reaches CTRL_RUN-1 on an is_ctrl cycle, go to LOCKED and clear the counters.
  - Otherwise: run_cnt <= 0, idle_cnt++. When idle_cnt == SEARCH_TIMEOUT-1, slip.
- State SETTLE:
  - Lasts exactly one cycle, because out still reflects the old offset.
  - Ignores is_ctrl, then goes to SEARCH.
- State LOCKED:
  - locked=1.
  - On is_ctrl: idle_cnt <= 0.
  - Otherwise idle_cnt++. When idle_cnt == LOSS_TIMEOUT-1, go to SEARCH with locked=0 and counters cleared. The offset is unchanged, so the current offset is retried first.
- Priority: slip_req overrides every other transition in the same cycle, including a lock completion or a timeout. From LOCKED it drops locked on the next edge.
- Wrap-around: offset 9 slips to 0. There is no limit on full sweeps; searching continues indefinitely.
- Reset mid-operation: asynchronous return to the reset values. The prev register is also cleared.

Decomposition:
- Shared package tmds_pkg:
  - TMDS control token constants: CTRL_00=0x354, CTRL_01=0x0AB, CTRL_10=0x154, CTRL_11=0x2AB.
  - The 16 TERC4 token constants.
  - The state encoding {SEARCH, SETTLE, LOCKED}.
  - The decoder and aligner both use the token constants.
- Sub-module tmds_barrel10: the combinational 20-to-10 rotator, inputs window and offset. Everything else stays in tmds_align.

Test Plan:
- Reset: assert reset_n=0 mid-stream, asynchronously between edges → out=0, offset=0, locked=0 and slip=0 immediately, before the next clk edge.
- Acquisition (SEARCH_TIMEOUT=32, CTRL_RUN=8):
  - Stimulus: continuous CTRL_00 stream serialized LSB-first, presented with the word boundary at bit 3.
  - Required: exactly 3 slip pulses, then offset=3, out=0x354, locked=1.
  - Lock must not occur at offsets 0..2, since no rotation of this stream other than 3 matches a token.
- Run threshold: at the correct offset, 7 control tokens followed by one pixel word → no lock, run_cnt restarts; 8 consecutive tokens → locked=1 on the edge after the 8th token appears on out.
- Loss (LOSS_TIMEOUT=64):
  - Stimulus: after lock, feed random pixel data containing no control tokens.
  - Required: locked falls after exactly 64 non-token words; offset is unchanged; a control stream then relocks at the same offset with no slip.
- Wrap and forced slip:
  - offset=9 plus slip_req → offset=0 with a single slip pulse.
  - slip_req while locked → locked=0 next cycle; SETTLE lasts one cycle; tokens arriving in that cycle are not counted.

Source files
------------

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS token constants and aligner state encoding
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  // TERC4 code words indexed by the 4-bit data-island nibble
  localparam logic [9:0] TERC4 [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] w);
    return (w == CTRL_00) || (w == CTRL_01) || (w == CTRL_10) || (w == CTRL_11);
  endfunction

endpackage

// File: rtl/tmds_barrel10.sv
// rtl/tmds_barrel10.sv - combinational 20-to-10 rotator selecting window[offset+9:offset]
module tmds_barrel10 (
  input  logic [19:0] window_i,
  input  logic [3:0]  offset_i,
  output logic [9:0]  word_o
);

  // Offsets 10..15 never occur; they fall back to offset 0.
  always_comb begin
    word_o = window_i[9:0];
    for (int k = 1; k < 10; k++) begin
      if (offset_i == 4'(k)) word_o = window_i[k +: 10];
    end
  end

endmodule

// File: rtl/tmds_align.sv
// rtl/tmds_align.sv - TMDS symbol-boundary aligner: rotates raw words until control tokens line up
module tmds_align
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 16384
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] in_i,
  input  logic       slip_req_i,
  output logic [9:0] out_o,
  output logic       locked_o,
  output logic [3:0] offset_o,
  output logic       slip_o
);

  localparam int RUN_W    = $clog2(CTRL_RUN + 1);
  localparam int IDLE_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(CTRL_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(CTRL_RUN);
  localparam logic [IDLE_W-1:0] SEARCH_LAST = IDLE_W'(SEARCH_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] LOSS_LAST   = IDLE_W'(LOSS_TIMEOUT - 1);

  logic [9:0]        prev_q, out_q, out_d;
  logic [3:0]        offset_q, offset_d;
  logic              locked_q, slip_q;
  align_state_e      state_q;
  logic [RUN_W-1:0]  run_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              is_ctrl, do_slip;

  tmds_barrel10 u_barrel (
    .window_i ({in_i, prev_q}),
    .offset_i (offset_q),
    .word_o   (out_d)
  );

  assign is_ctrl  = is_ctrl_token(out_q);
  assign offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  assign do_slip  = slip_req_i ||
                    ((state_q == SEARCH) && !is_ctrl && (idle_cnt_q == SEARCH_LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q     <= '0;
      out_q      <= '0;
      offset_q   <= '0;
      locked_q   <= 1'b0;
      slip_q     <= 1'b0;
      state_q    <= SEARCH;
      run_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      prev_q <= in_i;
      out_q  <= out_d;
      slip_q <= 1'b0;
      if (do_slip) begin
        // SETTLE covers the one word still rotated by the old offset.
        offset_q   <= offset_d;
        slip_q     <= 1'b1;
        locked_q   <= 1'b0;
        run_cnt_q  <= '0;
        idle_cnt_q <= '0;
        state_q    <= SETTLE;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (is_ctrl) begin
              idle_cnt_q <= '0;
              if (run_cnt_q == RUN_LAST) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                run_cnt_q <= '0;
              end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_q <= run_cnt_q + 1'b1;
              end
            end else begin
              run_cnt_q  <= '0;
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          SETTLE: state_q <= SEARCH;
          LOCKED: begin
            if (is_ctrl) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == LOSS_LAST) begin
              // Keep the offset: the same boundary is retried first.
              state_q    <= SEARCH;
              locked_q   <= 1'b0;
              run_cnt_q  <= '0;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign out_o    = out_q;
  assign locked_o = locked_q;
  assign offset_o = offset_q;
  assign slip_o   = slip_q;

endmodule

// File: tb/tb_tmds_align.sv
// tb/tb_tmds_align.sv - self-checking bench for tmds_align
module tb_tmds_align;

  localparam logic [9:0] T = 10'h354;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slip_req = 1'b0;
  logic [9:0] in_w = '0;
  logic [9:0] out_w;
  logic       locked, slip;
  logic [3:0] offset;

  int total = 0;
  int bad = 0;

  logic [9:0] exp_q[$];
  logic [9:0] mprev = '0;

  typedef struct {
    logic [9:0] w;
    logic       lk;
  } vec_t;
  vec_t tbl[19];

  tmds_align #(.CTRL_RUN(8), .SEARCH_TIMEOUT(32), .LOSS_TIMEOUT(64)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_i       (in_w),
    .slip_req_i (slip_req),
    .out_o      (out_w),
    .locked_o   (locked),
    .offset_o   (offset),
    .slip_o     (slip)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rot10(input logic [19:0] win, input int k);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) r[b] = win[b + k];
    return r;
  endfunction

  // Raw deserializer word when the serial token stream is shifted by d bits.
  function automatic logic [9:0] ser(input logic [9:0] tok, input int d);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = tok[(j + d) % 10];
    return r;
  endfunction

  function automatic logic is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Drive one word; when moff >= 0 the expected rotated output is queued and checked after the edge.
  task automatic cyc(input logic [9:0] w, input logic sr, input int moff);
    in_w = w;
    slip_req = sr;
    if (moff >= 0) exp_q.push_back(rot10({w, mprev}, moff));
    mprev = w;
    @(posedge clk);
    #1;
    slip_req = 1'b0;
    if (exp_q.size() > 0) chk("out", int'(out_w), int'(exp_q.pop_front()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] toks[4];
    logic [9:0] u, a, w;
    int nslip, nt;
    logic early, dropped;

    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int k = 0; k < 19; k++) begin
      tbl[k].w  = (k == 7) ? 10'h1F0 : toks[k % 4];
      tbl[k].lk = (k >= 17);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'(out_w), 0);
    chk("reset_offset", int'(offset), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_slip", int'(slip), 0);
    rst_n = 1'b1;
    mprev = '0;

    // 7 tokens, a pixel, then 8 tokens: lock only after the second run
    for (int k = 0; k < 19; k++) begin
      cyc(tbl[k].w, 1'b0, 0);
      chk("run_locked", int'(locked), int'(tbl[k].lk));
      chk("run_slip", int'(slip), 0);
    end
    chk("run_offset", int'(offset), 0);

    // Forced slip while locked; the token seen during SETTLE must not count
    u = ser(T, 9);
    cyc(u, 1'b1, 0);
    chk("fslip_pulse", int'(slip), 1);
    chk("fslip_unlock", int'(locked), 0);
    chk("fslip_offset", int'(offset), 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(u, 1'b0, 1);
      if (i == 1) chk("fslip_pulse_end", int'(slip), 0);
      chk("settle_lock", int'(locked), int'(i == 9));
    end

    // Acquisition with the boundary at bit 3
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mprev = '0;
    exp_q.delete();
    a = ser(T, 7);
    nslip = 0;
    early = 1'b0;
    for (int i = 0; i < 400 && !locked; i++) begin
      cyc(a, 1'b0, -1);
      if (slip) nslip++;
      if (locked && offset != 4'd3) early = 1'b1;
    end
    chk("acq_slips", nslip, 3);
    chk("acq_offset", int'(offset), 3);
    chk("acq_out", int'(out_w), int'(T));
    chk("acq_locked", int'(locked), 1);
    chk("acq_early_lock", int'(early), 0);

    // Loss of lock after 64 non-token words
    nt = 0;
    nslip = 0;
    dropped = 1'b0;
    for (int i = 0; i < 300; i++) begin
      do w = 10'($urandom); while (is_tok(rot10({w, mprev}, 3)));
      cyc(w, 1'b0, 3);
      if (slip) nslip++;
      if (!locked) begin
        dropped = 1'b1;
        break;
      end
      if (!is_tok(out_w)) nt++;
    end
    chk("loss_dropped", int'(dropped), 1);
    chk("loss_count", nt, 64);
    chk("loss_offset", int'(offset), 3);
    chk("loss_slips", nslip, 0);

    for (int i = 0; i < 40 && !locked; i++) begin
      cyc(a, 1'b0, 3);
      if (slip) nslip++;
    end
    chk("relock_locked", int'(locked), 1);
    chk("relock_offset", int'(offset), 3);
    chk("relock_slips", nslip, 0);
    chk("relock_out", int'(out_w), int'(T));

    // Asynchronous reset between edges
    in_w = a;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_out", int'(out_w), 0);
    chk("areset_offset", int'(offset), 0);
    chk("areset_locked", int'(locked), 0);
    chk("areset_slip", int'(slip), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mprev = '0;

    // Forced slips through every offset, including the 9 -> 0 wrap
    for (int k = 1; k <= 10; k++) begin
      cyc(10'($urandom), 1'b1, k - 1);
      chk("wrap_pulse", int'(slip), 1);
      chk("wrap_offset", int'(offset), k % 10);
      for (int j = 0; j < 3; j++) begin
        cyc(10'($urandom), 1'b0, k % 10);
        chk("wrap_pulse_low", int'(slip), 0);
        chk("wrap_offset_hold", int'(offset), k % 10);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
